// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and a
// slow line-oriented backing memory; misses stall the pipeline until the line is filled.
module dcache_ctrl #(
    parameter int INDEX_BITS = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [3:0]   cpu_be_i,
    input  logic [31:0]  cpu_wdata_i,
    output logic [31:0]  cpu_rdata_o,
    output logic         cpu_stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [127:0] mem_wdata_o,
    input  logic         mem_ack_i,
    input  logic [127:0] mem_rdata_i
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WB    = 2'd1;
    localparam logic [1:0] S_ALLOC = 2'd2;

    logic [1:0]       r_state;
    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [127:0]     r_data [LINES];
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [127:0]     r_mem_wdata;

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_W-1:0]      w_tag;
    logic [6:0]            w_base;
    logic [127:0]          w_line;
    logic [31:0]           w_mask;
    logic [31:0]           w_merged_word;
    logic [127:0]          w_merged_line;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_idle;
    logic                  w_store_hit;
    logic                  w_fill;
    logic                  w_wb_done;
    logic                  w_unused_addr;

    assign w_index       = cpu_addr_i[3+INDEX_BITS:4];
    assign w_tag         = cpu_addr_i[31:4+INDEX_BITS];
    assign w_base        = {cpu_addr_i[3:2], 5'b0};
    assign w_line        = r_data[w_index];
    assign w_unused_addr = ^cpu_addr_i[1:0];

    assign w_hit       = cpu_req_i & r_valid[w_index] & (r_tag[w_index] == w_tag);
    assign w_miss      = cpu_req_i & ~w_hit;
    assign w_idle      = (r_state == S_IDLE);
    assign w_store_hit = w_idle & w_hit & cpu_we_i;
    assign w_fill      = (r_state == S_ALLOC) & r_mem_req & mem_ack_i;
    assign w_wb_done   = (r_state == S_WB) & r_mem_req & mem_ack_i;

    // Stall must rise in the same cycle the miss is seen, so it is not registered.
    assign cpu_stall_o = ~w_idle | w_miss;
    assign cpu_rdata_o = w_line[w_base +: 32];

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

    always_comb begin
        w_mask        = {{8{cpu_be_i[3]}}, {8{cpu_be_i[2]}}, {8{cpu_be_i[1]}}, {8{cpu_be_i[0]}}};
        w_merged_word = (cpu_wdata_i & w_mask) | (w_line[w_base +: 32] & ~w_mask);
        w_merged_line = w_line;
        w_merged_line[w_base +: 32] = w_merged_word;
    end

    // Tag and data arrays carry no reset; the valid bits alone make them meaningful.
    always_ff @(posedge clk_i) begin
        if (w_fill) begin
            r_data[w_index] <= mem_rdata_i;
            r_tag[w_index]  <= w_tag;
        end else if (w_store_hit) begin
            r_data[w_index] <= w_merged_line;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_mem_req <= 1'b1;
                        if (r_valid[w_index] && r_dirty[w_index]) begin
                            r_state     <= S_WB;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {r_tag[w_index], w_index, 4'b0};
                            r_mem_wdata <= w_line;
                        end else begin
                            r_state    <= S_ALLOC;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {w_tag, w_index, 4'b0};
                        end
                    end else if (w_store_hit) begin
                        r_dirty[w_index] <= 1'b1;
                    end
                end
                // Request stays high straight into the fetch: no idle gap after write-back.
                S_WB: begin
                    if (w_wb_done) begin
                        r_dirty[w_index] <= 1'b0;
                        r_mem_we         <= 1'b0;
                        r_mem_addr       <= {w_tag, w_index, 4'b0};
                        r_state          <= S_ALLOC;
                    end
                end
                S_ALLOC: begin
                    if (w_fill) begin
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                        r_mem_req        <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: architectural memory model plus a slow backing-memory responder;
// expected load data and expected line transactions are queued at issue and compared on completion.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req, cpu_we;
    logic [31:0]  cpu_addr;
    logic [3:0]   cpu_be;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ack;
    logic [127:0] mem_rdata;

    always #5 clk = ~clk;

    dcache_ctrl #(.INDEX_BITS(5)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_be_i(cpu_be), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] data;
    } txn_t;

    int checks   = 0;
    int failures = 0;
    int lat      = 5;
    logic [31:0] bmem [logic [31:0]];
    logic [31:0] gm   [logic [31:0]];
    logic [31:0] rd_q [$];
    txn_t        exp_txn [$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bm_rd(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return a ^ 32'hA500_0000;
    endfunction

    function automatic logic [31:0] gm_rd(input logic [31:0] a);
        if (gm.exists(a)) return gm[a];
        return a ^ 32'hA500_0000;
    endfunction

    function automatic logic [127:0] gm_line(input logic [31:0] a);
        return {gm_rd(a + 32'd12), gm_rd(a + 32'd8), gm_rd(a + 32'd4), gm_rd(a)};
    endfunction

    task automatic set_mem(input logic [31:0] a, input logic [31:0] v);
        bmem[a] = v;
        gm[a]   = v;
    endtask

    task automatic push_txn(input logic we, input logic [31:0] a);
        txn_t t;
        t.we   = we;
        t.addr = a;
        t.data = we ? gm_line(a) : 128'd0;
        exp_txn.push_back(t);
    endtask

    // Issues one access and waits for it to complete; cpu_req stays high until the next access or idle.
    task automatic access(input string tag, input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input int exp_stalls);
        logic [31:0] wa, m, old;
        int n;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_be = be; cpu_wdata = wd;
        wa = {a[31:2], 2'b00};
        if (we) begin
            m   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            old = gm_rd(wa);
            gm[wa] = (wd & m) | (old & ~m);
        end else begin
            rd_q.push_back(gm_rd(wa));
        end
        n = 0;
        @(negedge clk);
        while (cpu_stall && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, ".stalls"}, n, exp_stalls);
        if (!we && rd_q.size() > 0) chk({tag, ".rdata"}, cpu_rdata, rd_q.pop_front());
    endtask

    task automatic idle();
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0;
    endtask

    // Backing memory: acks after lat request cycles and checks each transaction it serves.
    initial begin
        int   cnt;
        bit   ack_mine;
        logic last_we;
        txn_t t;
        cnt = 0; ack_mine = 0; last_we = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                cnt = 0;
                if (ack_mine) begin mem_ack = 1'b0; ack_mine = 0; end
            end else begin
                if (ack_mine) begin
                    mem_ack = 1'b0; ack_mine = 0;
                    if (last_we) chk("no_req_gap", mem_req, 1'b1);
                end
                if (mem_req) begin
                    cnt++;
                    if (cnt >= lat) begin
                        cnt = 0;
                        chk("txn_expected", (exp_txn.size() > 0) ? 1 : 0, 1);
                        if (exp_txn.size() > 0) begin
                            t = exp_txn.pop_front();
                            chk("txn_we", mem_we, t.we);
                            chk("txn_addr", mem_addr, t.addr);
                            if (t.we) chk("wb_data", mem_wdata, t.data);
                        end
                        if (mem_we) begin
                            for (int i = 0; i < 4; i++) bmem[mem_addr + 32'(4*i)] = mem_wdata[32*i +: 32];
                        end else begin
                            mem_rdata = {bm_rd(mem_addr + 32'd12), bm_rd(mem_addr + 32'd8),
                                         bm_rd(mem_addr + 32'd4), bm_rd(mem_addr)};
                        end
                        last_we  = mem_we;
                        mem_ack  = 1'b1;
                        ack_mine = 1;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        set_mem(32'h100, 32'h1111_1111);
        set_mem(32'h108, 32'h1234_5678);
        set_mem(32'h2104, 32'hCAFE_F00D);

        repeat (3) @(negedge clk);
        chk("rst.stall", cpu_stall, 1'b0);
        chk("rst.req", mem_req, 1'b0);
        chk("rst.we", mem_we, 1'b0);
        chk("rst.addr", mem_addr, 32'h0);
        chk("rst.wdata", mem_wdata, 128'h0);
        rst_n = 1'b1;

        push_txn(1'b0, 32'h100);
        access("ld100_miss", 1'b0, 32'h100, 4'hF, 32'h0, 6);
        access("ld100_hit", 1'b0, 32'h100, 4'hF, 32'h0, 0);
        access("st104_hit", 1'b1, 32'h104, 4'hF, 32'hDEAD_BEEF, 0);
        access("ld104_hit", 1'b0, 32'h104, 4'hF, 32'h0, 0);

        push_txn(1'b1, 32'h100);
        push_txn(1'b0, 32'h2100);
        access("ld2104_evict", 1'b0, 32'h2104, 4'hF, 32'h0, 11);

        push_txn(1'b0, 32'h100);
        access("st108_miss", 1'b1, 32'h108, 4'b0001, 32'h0000_00AB, 6);
        access("ld108_merged", 1'b0, 32'h108, 4'hF, 32'h0, 0);
        idle();

        // Reset in the middle of a line fetch; the dirty 0x100 line is lost with it.
        push_txn(1'b0, 32'h400);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h400; cpu_be = 4'hF;
        repeat (3) @(negedge clk);
        chk("alloc.req", mem_req, 1'b1);
        rst_n = 1'b0; cpu_req = 1'b0;
        #1;
        chk("midrst.req", mem_req, 1'b0);
        chk("midrst.addr", mem_addr, 32'h0);
        chk("midrst.stall", cpu_stall, 1'b0);
        exp_txn.delete();
        gm = bmem;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #3;
        mem_ack = 1'b1; mem_rdata = '1;
        @(posedge clk); #3;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stray.req", mem_req, 1'b0);
        chk("stray.stall", cpu_stall, 1'b0);

        push_txn(1'b0, 32'h100);
        access("ld100_after_rst", 1'b0, 32'h100, 4'hF, 32'h0, 6);

        push_txn(1'b0, 32'h300);
        access("st300_cold", 1'b1, 32'h300, 4'hF, 32'h5555_AAAA, 6);
        access("ld300_hit", 1'b0, 32'h300, 4'hF, 32'h0, 0);
        push_txn(1'b1, 32'h300);
        push_txn(1'b0, 32'h100);
        access("ld100_evict300", 1'b0, 32'h100, 4'hF, 32'h0, 11);

        access("st10c_be0", 1'b1, 32'h10C, 4'h0, 32'hFFFF_FFFF, 0);
        push_txn(1'b1, 32'h100);
        push_txn(1'b0, 32'h2100);
        access("ld2100_evict_be0", 1'b0, 32'h2100, 4'hF, 32'h0, 11);
        idle();

        repeat (20) @(negedge clk);
        chk("txn_drained", exp_txn.size(), 0);
        chk("rdq_drained", rd_q.size(), 0);
        chk("idle.req", mem_req, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache placed directly downstream of the CPU's data-write (MEM) stage, in place of the single-cycle data memory. It serves word loads/stores from the MEM stage, stalls the pipeline on a miss, and moves whole 16-byte lines to and from a slow backing memory over a req/ack handshake.

## Interface
- INDEX_BITS, 5: line index width; 2^INDEX_BITS lines; tag = 28-INDEX_BITS bits.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- cpu_req_i  in  1  MEM stage issues a load/store this cycle.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address; [1:0] ignored, [3:2] word in line, [3+INDEX_BITS:4] index, [31:4+INDEX_BITS] tag.
- cpu_be_i  in  4  store byte enables (bit n = byte n of the word).
- cpu_wdata_i  in  32  store data, byte lanes aligned to cpu_be_i.
- cpu_rdata_o  out  32  load data (whole word; sign/width extraction stays in the MEM stage).
- cpu_stall_o  out  1  freeze PC and all pipeline registers.
- mem_req_o  out  1  backing memory request, registered.
- mem_we_o  out  1  1 = line write-back, 0 = line fetch, registered.
- mem_addr_o  out  32  line-aligned address ([3:0] = 0), registered.
- mem_wdata_o  out  128  victim line, word 0 in [31:0], registered.
- mem_ack_i  in  1  one-cycle pulse: request done; read line valid this cycle.
- mem_rdata_i  in  128  fetched line, sampled when mem_ack_i = 1 and mem_we_o = 0.

## Operation
- Storage per line: valid, dirty, tag, 128-bit data. Reset clears all valid and dirty bits; tag/data are not reset.
- hit = cpu_req_i & valid[index] & (tag[index] == addr tag).
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no req: nothing happens; stall 0.
- IDLE, hit load: cpu_rdata_o = selected word combinationally; stall 0.
- IDLE, hit store: bytes with cpu_be_i set are written at the edge; dirty set; stall 0.
- IDLE, miss: cpu_stall_o = 1 combinationally in the same cycle. If the victim is valid & dirty, go to WRITEBACK and load mem_* with we=1, addr={victim tag, index, 4'b0}, wdata = victim line. Otherwise go to ALLOCATE and load mem_* with we=0, addr={req tag, index, 4'b0}.
- WRITEBACK: stall 1, mem_req_o held. On ack, go to ALLOCATE (fetch address loaded, mem_req_o stays 1) and clear dirty.
- ALLOCATE: stall 1. On ack, write mem_rdata_i into the line, set tag, valid=1, dirty=0, drop mem_req_o, and return to IDLE. The still-held request then hits, so stores merge after the fill.
- The CPU holds cpu_req_i, cpu_we_i, cpu_addr_i, cpu_be_i and cpu_wdata_i stable while stalled. Deasserting during a stall is illegal; the transaction completes regardless.
- mem_ack_i is ignored while mem_req_o = 0.
- Request with cpu_be_i = 0 on a store: treated as a hit/miss normally, no bytes change, dirty still set.

## Timing
- Reset values: cpu_stall_o 0 (absent a miss), cpu_rdata_o = array data (don't care), mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, state IDLE.
- Hit: 0 extra cycles.
- Clean miss seen in cycle 0: mem_req_o rises in cycle 1; ack in cycle k (k≥1); line filled at the end of cycle k; stall low in cycle k+1.
- Dirty miss: write-back ack in cycle j; fetch req continuous from cycle j+1; fill follows the clean-miss timing relative to the second ack.
- mem_req_o never drops between the write-back ack and the fetch (one-cycle gap is not allowed).
- Reset asserted mid-transaction: state goes to IDLE and mem_req_o goes to 0 immediately (asynchronously); all lines are invalid. A later ack is ignored.
- Index wrap: addresses differing only in tag conflict on the same line; the last access wins.

## Test plan
- Reset, then load 0x100 with backing memory holding 0x11111111 at 0x100 and ack after 5 cycles → stall high 6 cycles, mem_addr_o=0x100 we=0, rdata=0x11111111, then an immediate reload of 0x100 gives stall 0.
- Store 0xDEADBEEF be=4'b1111 to 0x104 after the fill (hit) → no stall, no mem_req_o; load 0x104 returns 0xDEADBEEF.
- Then load 0x2104 (same index, INDEX_BITS=5) → write-back: mem_addr_o=0x100, we=1, wdata[63:32]=0xDEADBEEF; then fetch 0x2100; final rdata = memory word at 0x2104.
- Store 0x000000AB be=4'b0001 to 0x108 after the word was 0x12345678 → load 0x108 returns 0x123456AB.
- Cold store miss to 0x300 → fetch with no write-back, then merge; line dirty; evicting 0x300 later writes it back.
- Assert rst_i low during ALLOCATE → mem_req_o 0 at once; after release, load 0x100 misses again; a stray ack is ignored.
